// File: rtl/interrupt_controller.sv
// Interrupt/exception controller: edge-detected pending lines, masked priority pick, flush/redirect/handler sequencing.
// Optional feature: define VECTORED_IRQ_EN to give each external line its own vector (16'h0010 + 2*irq_id).
module interrupt_controller (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  ext_irq,
  input  logic [2:0]  cause_in,
  input  logic [15:0] pc_in,
  input  logic        eret,
  input  logic        flush_ack,
  input  logic        mask_we,
  input  logic [3:0]  mask_wdata,
  output logic        flush_req,
  output logic        interrupts_signal,
  output logic [15:0] interrupts_addr,
  output logic [15:0] epc,
  output logic [2:0]  cause_reg,
  output logic [1:0]  irq_id,
  output logic [3:0]  irq_mask,
  output logic        in_handler,
  output logic        lost_exc
);

  typedef enum logic [1:0] {IDLE = 2'd0, FLUSH = 2'd1, REDIRECT = 2'd2, HANDLER = 2'd3} state_t;

  localparam logic [2:0] CAUSE_SYSCALL = 3'b011;
  localparam logic [2:0] CAUSE_NONE    = 3'b100;

  state_t      state_r;
  logic [3:0]  ext_prev_r;
  logic [3:0]  pending_r;
  logic [15:0] vec_r;
  logic [3:0]  rise_s;
  logic [3:0]  eligible_s;
  logic [3:0]  clear_s;
  logic [1:0]  low_idx_s;
  logic        take_sync_s;
  logic        take_ext_s;

  function automatic logic [1:0] lowest_idx(input logic [3:0] v);
    lowest_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) lowest_idx = i[1:0];
    end
  endfunction

  // Bad-instruction/overflow share one handler, syscall uses the reset-style vector.
  function automatic logic [15:0] sync_vector(input logic [2:0] c);
    case (c)
      CAUSE_SYSCALL: sync_vector = 16'h0000;
      default:       sync_vector = 16'h0002;
    endcase
  endfunction

  // Acceptance decisions for the current IDLE cycle.
  always_comb begin
    rise_s      = ext_irq & ~ext_prev_r;
    eligible_s  = pending_r & irq_mask;
    low_idx_s   = lowest_idx(eligible_s);
    take_sync_s = (state_r == IDLE) && (cause_in != CAUSE_NONE);
    take_ext_s  = (state_r == IDLE) && !take_sync_s && (eligible_s != 4'b0000);
    clear_s     = take_ext_s ? (4'b0001 << low_idx_s) : 4'b0000;
  end

  // Edge history, pending latch and mask register run in every state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ext_prev_r <= 4'b0000;
      pending_r  <= 4'b0000;
      irq_mask   <= 4'b0000;
    end else begin
      ext_prev_r <= ext_irq;
      pending_r  <= (pending_r & ~clear_s) | rise_s;
      if (mask_we) irq_mask <= mask_wdata;
      else         irq_mask <= irq_mask;
    end
  end

  // Sequencing FSM with registered strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r           <= IDLE;
      flush_req         <= 1'b0;
      interrupts_signal <= 1'b0;
      interrupts_addr   <= 16'h0000;
      epc               <= 16'h0000;
      cause_reg         <= 3'b000;
      irq_id            <= 2'd0;
      in_handler        <= 1'b0;
      lost_exc          <= 1'b0;
      vec_r             <= 16'h0000;
    end else begin
      interrupts_signal <= 1'b0;
      interrupts_addr   <= 16'h0000;
      case (state_r)
        IDLE: begin
          if (take_sync_s) begin
            cause_reg <= cause_in;
            irq_id    <= 2'd0;
            epc       <= (cause_in == CAUSE_SYSCALL) ? (pc_in + 16'd1) : pc_in;
            vec_r     <= sync_vector(cause_in);
            flush_req <= 1'b1;
            state_r   <= FLUSH;
          end else if (take_ext_s) begin
            cause_reg <= 3'b000;
            irq_id    <= low_idx_s;
            epc       <= pc_in;
`ifdef VECTORED_IRQ_EN
            vec_r     <= 16'h0010 + {13'd0, low_idx_s, 1'b0};
`else
            vec_r     <= 16'h0000;
`endif
            flush_req <= 1'b1;
            state_r   <= FLUSH;
          end else begin
            state_r   <= IDLE;
          end
        end
        FLUSH: begin
          if (flush_ack) begin
            flush_req         <= 1'b0;
            interrupts_signal <= 1'b1;
            interrupts_addr   <= vec_r;
            state_r           <= REDIRECT;
          end else begin
            state_r           <= FLUSH;
          end
        end
        REDIRECT: begin
          in_handler <= 1'b1;
          state_r    <= HANDLER;
        end
        HANDLER: begin
          // A second exception cannot nest; only flag it, epc/cause stay intact.
          if (cause_in != CAUSE_NONE) lost_exc <= 1'b1;
          else                        lost_exc <= lost_exc;
          if (eret) begin
            interrupts_signal <= 1'b1;
            interrupts_addr   <= epc;
            in_handler        <= 1'b0;
            state_r           <= IDLE;
          end else begin
            state_r           <= HANDLER;
          end
        end
        default: begin
          flush_req  <= 1'b0;
          in_handler <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: a per-cycle vector table plus hand-written corner sequences.
module tb_interrupt_controller;

  logic        clk;
  logic        reset_n;
  logic [3:0]  ext_irq;
  logic [2:0]  cause_in;
  logic [15:0] pc_in;
  logic        eret;
  logic        flush_ack;
  logic        mask_we;
  logic [3:0]  mask_wdata;
  logic        flush_req;
  logic        interrupts_signal;
  logic [15:0] interrupts_addr;
  logic [15:0] epc;
  logic [2:0]  cause_reg;
  logic [1:0]  irq_id;
  logic [3:0]  irq_mask;
  logic        in_handler;
  logic        lost_exc;

  int errors = 0;
  int checks = 0;

`ifdef VECTORED_IRQ_EN
  localparam bit VEC = 1'b1;
`else
  localparam bit VEC = 1'b0;
`endif

  interrupt_controller dut (
    .clk(clk), .reset_n(reset_n), .ext_irq(ext_irq), .cause_in(cause_in), .pc_in(pc_in),
    .eret(eret), .flush_ack(flush_ack), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .flush_req(flush_req), .interrupts_signal(interrupts_signal), .interrupts_addr(interrupts_addr),
    .epc(epc), .cause_reg(cause_reg), .irq_id(irq_id), .irq_mask(irq_mask),
    .in_handler(in_handler), .lost_exc(lost_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  ext;
    logic [2:0]  cause;
    logic [15:0] pc;
    logic        er;
    logic        ack;
    logic        mwe;
    logic [3:0]  mdata;
    logic        fr;
    logic        sig;
    logic [15:0] addr;
    logic [15:0] epc;
    logic [2:0]  cr;
    logic [1:0]  id;
    logic [3:0]  mask;
    logic        inh;
    logic        lost;
  } vec_t;

  vec_t tbl [17];

  function automatic logic [15:0] ext_addr(input logic [1:0] id);
    ext_addr = VEC ? (16'h0010 + {13'd0, id, 1'b0}) : 16'h0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ext_irq = 4'b0000; cause_in = 3'b100; pc_in = 16'h0000;
    eret = 1'b0; flush_ack = 1'b0; mask_we = 1'b0; mask_wdata = 4'b0000;
  endtask

  function automatic logic [63:0] outs();
    outs = {19'd0, flush_req, interrupts_signal, interrupts_addr, epc, cause_reg, irq_id,
            irq_mask, in_handler, lost_exc};
  endfunction

  initial begin
    // {ext, cause, pc, eret, ack, mwe, mdata | fr, sig, addr, epc, cause_reg, irq_id, mask, in_handler, lost}
    tbl[0]  = '{4'h0, 3'b100, 16'h0000, 1'b0, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'b000, 2'd0, 4'hF, 1'b0, 1'b0};
    tbl[1]  = '{4'h6, 3'b100, 16'h0040, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'b000, 2'd0, 4'hF, 1'b0, 1'b0};
    tbl[2]  = '{4'h6, 3'b100, 16'h0040, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 16'h0000, 16'h0040, 3'b000, 2'd1, 4'hF, 1'b0, 1'b0};
    tbl[3]  = '{4'h6, 3'b100, 16'h0040, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 16'h0000, 16'h0040, 3'b000, 2'd1, 4'hF, 1'b0, 1'b0};
    tbl[4]  = '{4'h6, 3'b100, 16'h0040, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, ext_addr(2'd1), 16'h0040, 3'b000, 2'd1, 4'hF, 1'b0, 1'b0};
    tbl[5]  = '{4'h6, 3'b100, 16'h0040, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 16'h0000, 16'h0040, 3'b000, 2'd1, 4'hF, 1'b1, 1'b0};
    tbl[6]  = '{4'h6, 3'b100, 16'h0040, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 16'h0040, 16'h0040, 3'b000, 2'd1, 4'hF, 1'b0, 1'b0};
    // Line 2 lost arbitration earlier and must still be pending.
    tbl[7]  = '{4'h6, 3'b100, 16'h0050, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 16'h0000, 16'h0050, 3'b000, 2'd2, 4'hF, 1'b0, 1'b0};
    tbl[8]  = '{4'h6, 3'b100, 16'h0050, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, ext_addr(2'd2), 16'h0050, 3'b000, 2'd2, 4'hF, 1'b0, 1'b0};
    tbl[9]  = '{4'h6, 3'b100, 16'h0050, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 16'h0000, 16'h0050, 3'b000, 2'd2, 4'hF, 1'b1, 1'b0};
    tbl[10] = '{4'h6, 3'b100, 16'h0050, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 16'h0050, 16'h0050, 3'b000, 2'd2, 4'hF, 1'b0, 1'b0};
    tbl[11] = '{4'h0, 3'b100, 16'h0000, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 16'h0000, 16'h0050, 3'b000, 2'd2, 4'hF, 1'b0, 1'b0};
    tbl[12] = '{4'h0, 3'b011, 16'h0100, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 16'h0000, 16'h0101, 3'b011, 2'd0, 4'hF, 1'b0, 1'b0};
    tbl[13] = '{4'h0, 3'b100, 16'h0000, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 16'h0000, 16'h0101, 3'b011, 2'd0, 4'hF, 1'b0, 1'b0};
    tbl[14] = '{4'h0, 3'b100, 16'h0000, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 16'h0000, 16'h0101, 3'b011, 2'd0, 4'hF, 1'b1, 1'b0};
    tbl[15] = '{4'h0, 3'b100, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 16'h0101, 16'h0101, 3'b011, 2'd0, 4'hF, 1'b0, 1'b0};
    tbl[16] = '{4'h0, 3'b100, 16'h0000, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 16'h0000, 16'h0101, 3'b011, 2'd0, 4'hF, 1'b0, 1'b0};

    idle_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    check("reset_state", outs(), 64'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      ext_irq = tbl[i].ext; cause_in = tbl[i].cause; pc_in = tbl[i].pc;
      eret = tbl[i].er; flush_ack = tbl[i].ack; mask_we = tbl[i].mwe; mask_wdata = tbl[i].mdata;
      tick();
      check($sformatf("vec%0d", i), outs(),
            {19'd0, tbl[i].fr, tbl[i].sig, tbl[i].addr, tbl[i].epc, tbl[i].cr, tbl[i].id,
             tbl[i].mask, tbl[i].inh, tbl[i].lost});
    end

    // Overflow and an ext_irq[0] edge in the same cycle: exception wins, line 0 waits.
    idle_inputs();
    cause_in = 3'b010; ext_irq = 4'b0001; pc_in = 16'h0200;
    tick();
    check("ovf_accept", {flush_req, epc, cause_reg}, {1'b1, 16'h0200, 3'b010});
    cause_in = 3'b100; flush_ack = 1'b1;
    tick();
    check("ovf_redirect", {interrupts_signal, interrupts_addr}, {1'b1, 16'h0002});
    flush_ack = 1'b0;
    tick();
    eret = 1'b1;
    tick();
    check("ovf_eret", {interrupts_signal, interrupts_addr, in_handler}, {1'b1, 16'h0200, 1'b0});
    eret = 1'b0; pc_in = 16'h0300;
    tick();
    check("ext0_after_eret", {flush_req, cause_reg, irq_id, epc}, {1'b1, 3'b000, 2'd0, 16'h0300});
    flush_ack = 1'b1;
    tick();
    check("ext0_redirect", {interrupts_signal, interrupts_addr}, {1'b1, ext_addr(2'd0)});
    flush_ack = 1'b0;
    tick();

    // Exception raised inside the handler only sets the sticky flag.
    cause_in = 3'b001; pc_in = 16'h0999;
    tick();
    check("lost_exc_set", {lost_exc, epc, cause_reg, interrupts_signal, flush_req},
          {1'b1, 16'h0300, 3'b000, 1'b0, 1'b0});
    cause_in = 3'b100;
    tick();
    check("lost_no_redirect", {interrupts_signal, flush_req, in_handler}, {1'b0, 1'b0, 1'b1});
    eret = 1'b1;
    tick();
    check("lost_eret", {interrupts_signal, interrupts_addr, lost_exc}, {1'b1, 16'h0300, 1'b1});
    eret = 1'b0;

    // Masked line 3 sits pending until the mask write opens it.
    mask_we = 1'b1; mask_wdata = 4'b0000;
    tick();
    mask_we = 1'b0; ext_irq = 4'b1000; pc_in = 16'h0400;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("masked_idle%0d", i), {flush_req, interrupts_signal}, 2'b00);
    end
    mask_we = 1'b1; mask_wdata = 4'b1000;
    tick();
    check("mask_write", {flush_req, irq_mask}, {1'b0, 4'b1000});
    mask_we = 1'b0;
    tick();
    check("mask_accept", {flush_req, irq_id, epc}, {1'b1, 2'd3, 16'h0400});
    flush_ack = 1'b1;
    tick();
    check("ext3_redirect", {interrupts_signal, interrupts_addr}, {1'b1, ext_addr(2'd3)});
    flush_ack = 1'b0;
    tick();
    eret = 1'b1;
    tick();
    eret = 1'b0; ext_irq = 4'b0000;

    // Reset while flushing aborts the sequence with no redirect.
    cause_in = 3'b001; pc_in = 16'h0500;
    tick();
    check("pre_reset_flush", flush_req, 64'd1);
    cause_in = 3'b100; flush_ack = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check("reset_abort", outs(), 64'd0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("post_reset%0d", i), {interrupts_signal, flush_req}, 2'b00);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
